id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//  ID/EX pipeline stage directly upstream of the ALU. Registers the decoded instruction,
//  turns ALUOp/funct into the 4-bit ALU mode, forwards EX/MEM and MEM/WB results onto the
//  operands, and inserts a one-cycle bubble on load-use hazards.
//  Drives the ALU a/b/mode inputs and the control bits consumed by later stages.
// PARAMETERS
//  XLEN     32  datapath width
//  REGBITS   5  register-number width
// PORTS
//  clk          in   1        clock; all state updates on rising edge
//  rst_n        in   1        asynchronous active-low reset
//  in_valid     in   1        decode presents an instruction
//  in_ready     out  1        stage accepts (comb)
//  in_rs_data   in   XLEN     register-file rs value
//  in_rt_data   in   XLEN     register-file rt value
//  in_imm       in   XLEN     sign-extended immediate
//  in_rs/in_rt/in_rd in REGBITS  register numbers
//  in_alu_op    in   2        00 add, 01 sub, 10 R-type (funct), 11 or
//  in_funct     in   6        instruction funct field
//  in_alu_src   in   1        1: operand b = imm
//  in_uses_rt   in   1        instruction reads rt as a source
//  in_reg_write, in_mem_read, in_mem_write, in_mem_to_reg, in_reg_dst  in 1 each
//  flush        in   1        squash stage contents (taken branch)
//  out_ready    in   1        downstream can take the instruction
//  out_valid    out  1        stage holds a valid instruction
//  alu_a, alu_b out  XLEN     ALU operands after forwarding (comb from regs + fwd)
//  alu_mode     out  4        registered ALU mode
//  out_dest     out  REGBITS  destination (rd if reg_dst else rt)
//  out_rt_data  out  XLEN     forwarded rt value (store data)
//  out_reg_write, out_mem_read, out_mem_write, out_mem_to_reg  out 1 each  registered
//  out_illegal  out  1        R-type funct not decodable
//  exmem_reg_write/exmem_rd/exmem_result  in 1/REGBITS/XLEN  EX/MEM forwarding source
//  memwb_reg_write/memwb_rd/memwb_result  in 1/REGBITS/XLEN  MEM/WB forwarding source
// BEHAVIOUR
//  Reset: valid_q=0; all registered fields incl. alu_mode, out_* = 0 (alu_mode=AND).
//  hazard   = valid_q & mem_read_q & dest_q!=0 & (dest_q==in_rs | (in_uses_rt & dest_q==in_rt)).
//  in_ready = flush | ((~valid_q | out_ready) & ~hazard).
//  Priority per edge: flush > capture > bubble > hold.
//   flush: valid_q<=0; any offered instruction accepted and dropped.
//   in_valid&in_ready: load all fields, valid_q<=1 (back-to-back at 1/cycle).
//   hazard & out_ready: valid_q<=0 (single bubble); next cycle hazard clears.
//   else out_ready: valid_q<=0; else hold all fields unchanged.
//  Mode decode: op00->0010, op01->0110, op11->0001; op10 funct 100000->0010,
//   100010->0110, 100100->0000, 100101->0001, 100111->1100, 101010->0111;
//   other funct -> 0010 with out_illegal=1.
//  Forwarding per operand (rs, rt): src!=0 & exmem_reg_write & exmem_rd==src -> exmem_result;
//   else memwb_reg_write & memwb_rd==src -> memwb_result; else registered value.
//   EX/MEM beats MEM/WB. Register 0 never forwarded.
//  alu_b = alu_src_q ? imm_q : forwarded rt. out_rt_data always forwarded rt.
//  Outputs valid only while out_valid=1; ALU latches operands one edge later (registered
//   result). Reset mid-operation drops the held instruction; no replay.
// STRUCTURE
//  mips_pkg: ALU mode constants (AND/OR/ADD/SUB/MIN/NOR), ALUOp encodings, funct codes.
//  Sub-module alu_ctrl_decode (comb: alu_op, funct -> mode, illegal); rest flat here.
// TESTING
//  1 reset mid-stream, rst_n=0 -> out_valid=0, alu_mode=0000 immediately (async).
//  2 R-type add rs=3 (5), rt=4 (7), no fwd -> alu_a=5, alu_b=7, mode 0010, 1 cycle later.
//  3 exmem_rd=3=memwb_rd, results 0xAA/0xBB -> alu_a=0xAA; rs=0 with exmem_rd=0 -> no fwd.
//  4 lw to $8 then add $9,$8,$1 -> in_ready=0 one cycle, bubble, add issues next cycle.
//  5 out_ready=0 for 3 cycles -> fields held, in_ready=0; flush during stall -> out_valid=0.
//  6 op10 funct 101010 -> 0111; 100111 -> 1100; 000001 -> 0010, out_illegal=1; op11 -> 0001.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS-style execute path: ALU modes, ALUOp classes, R-type funct codes.
package mips_pkg;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110,
    ALU_MIN = 4'b0111,
    ALU_NOR = 4'b1100
  } alu_mode_e;

  typedef enum logic [1:0] {
    OP_ADD   = 2'b00,
    OP_SUB   = 2'b01,
    OP_RTYPE = 2'b10,
    OP_OR    = 2'b11
  } alu_op_e;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational ALUOp/funct to 4-bit ALU mode decoder; undecodable R-type funct falls back to ADD.
module alu_ctrl_decode
  import mips_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [3:0] mode,
  output logic       illegal
);

  always_comb begin
    mode    = ALU_ADD;
    illegal = 1'b0;
    case (alu_op_e'(alu_op))
      OP_ADD: mode = ALU_ADD;
      OP_SUB: mode = ALU_SUB;
      OP_OR:  mode = ALU_OR;
      OP_RTYPE: begin
        case (funct)
          FN_ADD:  mode = ALU_ADD;
          FN_SUB:  mode = ALU_SUB;
          FN_AND:  mode = ALU_AND;
          FN_OR:   mode = ALU_OR;
          FN_NOR:  mode = ALU_NOR;
          FN_SLT:  mode = ALU_MIN;
          default: begin
            mode    = ALU_ADD;
            illegal = 1'b1;
          end
        endcase
      end
      default: mode = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures decoded instruction, decodes ALU mode, forwards
// EX/MEM and MEM/WB results onto operands, and bubbles on load-use hazards.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned REGBITS = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [XLEN-1:0]    in_rs_data,
  input  logic [XLEN-1:0]    in_rt_data,
  input  logic [XLEN-1:0]    in_imm,
  input  logic [REGBITS-1:0] in_rs,
  input  logic [REGBITS-1:0] in_rt,
  input  logic [REGBITS-1:0] in_rd,
  input  logic [1:0]         in_alu_op,
  input  logic [5:0]         in_funct,
  input  logic               in_alu_src,
  input  logic               in_uses_rt,
  input  logic               in_reg_write,
  input  logic               in_mem_read,
  input  logic               in_mem_write,
  input  logic               in_mem_to_reg,
  input  logic               in_reg_dst,
  input  logic               flush,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [XLEN-1:0]    alu_a,
  output logic [XLEN-1:0]    alu_b,
  output logic [3:0]         alu_mode,
  output logic [REGBITS-1:0] out_dest,
  output logic [XLEN-1:0]    out_rt_data,
  output logic               out_reg_write,
  output logic               out_mem_read,
  output logic               out_mem_write,
  output logic               out_mem_to_reg,
  output logic               out_illegal,
  input  logic               exmem_reg_write,
  input  logic [REGBITS-1:0] exmem_rd,
  input  logic [XLEN-1:0]    exmem_result,
  input  logic               memwb_reg_write,
  input  logic [REGBITS-1:0] memwb_rd,
  input  logic [XLEN-1:0]    memwb_result
);

  logic               valid_q;
  logic [XLEN-1:0]    rs_data_q, rt_data_q, imm_q;
  logic [REGBITS-1:0] rs_q, rt_q, dest_q;
  logic [3:0]         mode_q;
  logic               illegal_q, alu_src_q;
  logic               reg_write_q, mem_read_q, mem_write_q, mem_to_reg_q;

  logic [3:0]         dec_mode;
  logic               dec_illegal;
  logic               hazard;
  logic               capture;
  logic [XLEN-1:0]    fwd_rs, fwd_rt;

  alu_ctrl_decode u_dec (
    .alu_op  (in_alu_op),
    .funct   (in_funct),
    .mode    (dec_mode),
    .illegal (dec_illegal)
  );

  // Load in stage whose result the offered instruction needs: hold decode one cycle.
  assign hazard = valid_q && mem_read_q && (dest_q != '0) &&
                  ((dest_q == in_rs) || (in_uses_rt && (dest_q == in_rt)));
  assign in_ready = flush || ((!valid_q || out_ready) && !hazard);
  assign capture  = in_valid && in_ready && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q      <= 1'b0;
      rs_data_q    <= '0;
      rt_data_q    <= '0;
      imm_q        <= '0;
      rs_q         <= '0;
      rt_q         <= '0;
      dest_q       <= '0;
      mode_q       <= ALU_AND;
      illegal_q    <= 1'b0;
      alu_src_q    <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (capture) begin
      valid_q      <= 1'b1;
      rs_data_q    <= in_rs_data;
      rt_data_q    <= in_rt_data;
      imm_q        <= in_imm;
      rs_q         <= in_rs;
      rt_q         <= in_rt;
      dest_q       <= in_reg_dst ? in_rd : in_rt;
      mode_q       <= dec_mode;
      illegal_q    <= dec_illegal;
      alu_src_q    <= in_alu_src;
      reg_write_q  <= in_reg_write;
      mem_read_q   <= in_mem_read;
      mem_write_q  <= in_mem_write;
      mem_to_reg_q <= in_mem_to_reg;
    end else if (out_ready) begin
      // Covers both the load-use bubble and a plain drain with nothing offered.
      valid_q <= 1'b0;
    end
  end

  always_comb begin
    fwd_rs = rs_data_q;
    if ((rs_q != '0) && exmem_reg_write && (exmem_rd == rs_q))
      fwd_rs = exmem_result;
    else if ((rs_q != '0) && memwb_reg_write && (memwb_rd == rs_q))
      fwd_rs = memwb_result;

    fwd_rt = rt_data_q;
    if ((rt_q != '0) && exmem_reg_write && (exmem_rd == rt_q))
      fwd_rt = exmem_result;
    else if ((rt_q != '0) && memwb_reg_write && (memwb_rd == rt_q))
      fwd_rt = memwb_result;
  end

  assign out_valid      = valid_q;
  assign alu_a          = fwd_rs;
  assign alu_b          = alu_src_q ? imm_q : fwd_rt;
  assign alu_mode       = mode_q;
  assign out_dest       = dest_q;
  assign out_rt_data    = fwd_rt;
  assign out_reg_write  = reg_write_q;
  assign out_mem_read   = mem_read_q;
  assign out_mem_write  = mem_write_q;
  assign out_mem_to_reg = mem_to_reg_q;
  assign out_illegal    = illegal_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, decode, forwarding, load-use bubble, stall/flush.
module tb_id_ex_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [31:0] in_rs_data, in_rt_data, in_imm;
  logic [4:0]  in_rs, in_rt, in_rd;
  logic [1:0]  in_alu_op;
  logic [5:0]  in_funct;
  logic        in_alu_src, in_uses_rt, in_reg_write, in_mem_read, in_mem_write;
  logic        in_mem_to_reg, in_reg_dst, flush, out_ready, out_valid;
  logic [31:0] alu_a, alu_b, out_rt_data;
  logic [3:0]  alu_mode;
  logic [4:0]  out_dest;
  logic        out_reg_write, out_mem_read, out_mem_write, out_mem_to_reg, out_illegal;
  logic        exmem_reg_write, memwb_reg_write;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_result, memwb_result;

  int checks = 0;
  int failures = 0;

  id_ex_stage #(.XLEN(32), .REGBITS(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs_data(in_rs_data), .in_rt_data(in_rt_data), .in_imm(in_imm),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_alu_op(in_alu_op),
    .in_funct(in_funct), .in_alu_src(in_alu_src), .in_uses_rt(in_uses_rt),
    .in_reg_write(in_reg_write), .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
    .in_mem_to_reg(in_mem_to_reg), .in_reg_dst(in_reg_dst), .flush(flush),
    .out_ready(out_ready), .out_valid(out_valid), .alu_a(alu_a), .alu_b(alu_b),
    .alu_mode(alu_mode), .out_dest(out_dest), .out_rt_data(out_rt_data),
    .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
    .out_mem_write(out_mem_write), .out_mem_to_reg(out_mem_to_reg),
    .out_illegal(out_illegal), .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd),
    .exmem_result(exmem_result), .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd),
    .memwb_result(memwb_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 0; in_rs_data = 0; in_rt_data = 0; in_imm = 0;
    in_rs = 0; in_rt = 0; in_rd = 0; in_alu_op = 2'b00; in_funct = 6'b0;
    in_alu_src = 0; in_uses_rt = 0; in_reg_write = 0; in_mem_read = 0;
    in_mem_write = 0; in_mem_to_reg = 0; in_reg_dst = 0; flush = 0; out_ready = 1;
    exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
    memwb_reg_write = 0; memwb_rd = 0; memwb_result = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    #3;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", out_valid); end
    checks++;
    if (alu_mode !== 4'b0000) begin failures++; $display("FAIL reset_mode got=%b exp=0000", alu_mode); end
    checks++;
    if (out_reg_write !== 1'b0 || out_mem_read !== 1'b0 || out_dest !== 5'd0) begin
      failures++; $display("FAIL reset_ctrl got rw=%0b mr=%0b dest=%0d exp 0/0/0", out_reg_write, out_mem_read, out_dest);
    end
    #10 rst_n = 1;
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL reset_idle got valid=%0b ready=%0b exp 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_rtype_add();
    in_valid = 1; in_alu_op = 2'b10; in_funct = 6'b100000;
    in_rs = 3; in_rs_data = 5; in_rt = 4; in_rt_data = 7; in_rd = 5;
    in_reg_dst = 1; in_reg_write = 1; in_uses_rt = 1; in_alu_src = 0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL add_ready got=%0b exp=1", in_ready); end
    tick();
    in_valid = 0;
    checks++;
    if (out_valid !== 1'b1) begin failures++; $display("FAIL add_valid got=%0b exp=1", out_valid); end
    checks++;
    if (alu_a !== 32'd5 || alu_b !== 32'd7) begin
      failures++; $display("FAIL add_operands got a=%0d b=%0d exp 5/7", alu_a, alu_b);
    end
    checks++;
    if (alu_mode !== 4'b0010 || out_dest !== 5'd5 || out_reg_write !== 1'b1 || out_illegal !== 1'b0) begin
      failures++; $display("FAIL add_ctrl got mode=%b dest=%0d rw=%0b ill=%0b exp 0010/5/1/0",
                           alu_mode, out_dest, out_reg_write, out_illegal);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL add_drain got=%0b exp=0", out_valid); end
  endtask

  task automatic test_forwarding();
    idle_inputs();
    in_valid = 1; in_rs = 3; in_rs_data = 1; in_rt = 4; in_rt_data = 2;
    in_alu_src = 1; in_imm = 32'h40; in_uses_rt = 1;
    tick();
    in_valid = 0;
    exmem_reg_write = 1; exmem_rd = 3; exmem_result = 32'hAA;
    memwb_reg_write = 1; memwb_rd = 3; memwb_result = 32'hBB;
    #1;
    checks++;
    if (alu_a !== 32'hAA) begin failures++; $display("FAIL fwd_exmem_priority got=%h exp=aa", alu_a); end
    checks++;
    if (alu_b !== 32'h40 || out_rt_data !== 32'd2) begin
      failures++; $display("FAIL fwd_imm_b got b=%h rt=%h exp 40/2", alu_b, out_rt_data);
    end
    exmem_reg_write = 0;
    #1;
    checks++;
    if (alu_a !== 32'hBB) begin failures++; $display("FAIL fwd_memwb got=%h exp=bb", alu_a); end
    memwb_rd = 4;
    #1;
    checks++;
    if (alu_a !== 32'd1 || out_rt_data !== 32'hBB || alu_b !== 32'h40) begin
      failures++; $display("FAIL fwd_rt_store got a=%h rt=%h b=%h exp 1/bb/40", alu_a, out_rt_data, alu_b);
    end
    @(negedge clk);
    in_valid = 1; in_rs = 0; in_rs_data = 32'h11; in_rt = 0; in_rt_data = 32'h22; in_alu_src = 0;
    exmem_reg_write = 1; exmem_rd = 0; memwb_reg_write = 1; memwb_rd = 0;
    tick();
    in_valid = 0;
    checks++;
    if (alu_a !== 32'h11 || alu_b !== 32'h22) begin
      failures++; $display("FAIL fwd_reg0 got a=%h b=%h exp 11/22", alu_a, alu_b);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_load_use();
    in_valid = 1; in_alu_op = 2'b00; in_rs = 1; in_rs_data = 32'h100; in_rt = 8;
    in_imm = 4; in_alu_src = 1; in_reg_dst = 0; in_mem_read = 1; in_mem_to_reg = 1;
    in_reg_write = 1; in_uses_rt = 0;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_mem_read !== 1'b1 || out_dest !== 5'd8 || alu_b !== 32'd4) begin
      failures++; $display("FAIL lw_capture got v=%0b mr=%0b dest=%0d b=%0d exp 1/1/8/4",
                           out_valid, out_mem_read, out_dest, alu_b);
    end
    in_rs = 2; in_rt = 8; in_uses_rt = 0; in_mem_read = 0; in_mem_to_reg = 0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL lu_rt_unused got=%0b exp=1", in_ready); end
    in_alu_op = 2'b10; in_funct = 6'b100000; in_rs = 8; in_rs_data = 32'h30;
    in_rt = 1; in_rt_data = 32'h31; in_rd = 9; in_reg_dst = 1; in_uses_rt = 1; in_alu_src = 0;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL lu_stall got=%0b exp=0", in_ready); end
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL lu_bubble got v=%0b ready=%0b exp 0/1", out_valid, in_ready);
    end
    tick();
    in_valid = 0;
    checks++;
    if (out_valid !== 1'b1 || out_dest !== 5'd9 || out_mem_read !== 1'b0 || alu_mode !== 4'b0010 ||
        alu_a !== 32'h30 || alu_b !== 32'h31) begin
      failures++; $display("FAIL lu_issue got v=%0b dest=%0d mr=%0b mode=%b a=%h b=%h exp 1/9/0/0010/30/31",
                           out_valid, out_dest, out_mem_read, alu_mode, alu_a, alu_b);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_stall_flush();
    in_valid = 1; in_alu_op = 2'b01; in_rs = 2; in_rs_data = 9; in_alu_src = 1; in_imm = 3;
    tick();
    in_alu_op = 2'b11; in_rs_data = 32'h77; in_imm = 32'h55; out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0) begin failures++; $display("FAIL stall_ready[%0d] got=%0b exp=0", i, in_ready); end
      tick();
      checks++;
      if (out_valid !== 1'b1 || alu_a !== 32'd9 || alu_b !== 32'd3 || alu_mode !== 4'b0110) begin
        failures++; $display("FAIL stall_hold[%0d] got v=%0b a=%0d b=%0d mode=%b exp 1/9/3/0110",
                             i, out_valid, alu_a, alu_b, alu_mode);
      end
    end
    flush = 1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL flush_ready got=%0b exp=1", in_ready); end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got=%0b exp=0", out_valid); end
    idle_inputs();
    tick();
  endtask

  task automatic test_back_to_back_modes();
    logic [1:0] ops   [9] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b11, 2'b01};
    logic [5:0] fns   [9] = '{6'b101010, 6'b100111, 6'b000001, 6'b100010, 6'b100100,
                              6'b100101, 6'b100000, 6'b000000, 6'b000000};
    logic [3:0] modes [9] = '{4'b0111, 4'b1100, 4'b0010, 4'b0110, 4'b0000,
                              4'b0001, 4'b0010, 4'b0001, 4'b0110};
    logic       ills  [9] = '{0, 0, 1, 0, 0, 0, 0, 0, 0};
    in_valid = 1; in_rs = 6;
    for (int i = 0; i < 9; i++) begin
      in_alu_op = ops[i]; in_funct = fns[i]; in_rs_data = 32'(100 + i);
      tick();
      checks++;
      if (out_valid !== 1'b1 || alu_mode !== modes[i] || out_illegal !== ills[i] || alu_a !== 32'(100 + i)) begin
        failures++; $display("FAIL mode[%0d] got v=%0b mode=%b ill=%0b a=%0d exp 1/%b/%0b/%0d",
                             i, out_valid, alu_mode, out_illegal, alu_a, modes[i], ills[i], 100 + i);
      end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_midstream();
    in_valid = 1; in_alu_op = 2'b01; in_reg_write = 1;
    tick();
    in_valid = 0;
    checks++;
    if (out_valid !== 1'b1 || alu_mode !== 4'b0110) begin
      failures++; $display("FAIL mid_pre got v=%0b mode=%b exp 1/0110", out_valid, alu_mode);
    end
    #2 rst_n = 0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || alu_mode !== 4'b0000 || out_reg_write !== 1'b0) begin
      failures++; $display("FAIL mid_reset got v=%0b mode=%b rw=%0b exp 0/0000/0", out_valid, alu_mode, out_reg_write);
    end
    #2 rst_n = 1;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_noreplay got=%0b exp=0", out_valid); end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_rtype_add();
    test_forwarding();
    test_load_use();
    test_stall_flush();
    test_back_to_back_modes();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
